// File: rtl/ocio_pkg.sv
// Shared types and constants for the OCIO frontend.
//   ocio_byte_t : one 8-bit port word
//   oe_state_t  : output-enable sequencer states
package ocio_pkg;

  localparam int OCIO_BYTE_W = 8;

  typedef logic [OCIO_BYTE_W-1:0] ocio_byte_t;

  typedef enum logic [1:0] {
    OE_OFF,
    OE_WAIT,
    OE_ON
  } oe_state_t;

endpackage

// File: rtl/ocio_in_port.sv
// One OCIO input port: pin/strobe synchroniser, word-wide debouncer,
// strobe edge detector, capture latch with pending/ack handshake and a
// sticky overrun flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pin          raw 8-bit input pins
//   stb_pin      raw strobe pin
//   deb_len      stable cycles required (0 = bypass)
//   latch_en     1 = strobe latch mode, 0 = transparent debounced
//   stb_pol      1 = falling strobe edge active, 0 = rising
//   ack          clears pending
//   err_clr      clears sticky overrun
//   data         port value towards the register bank
//   pend         latched word waiting for ack
//   ovr          sticky overrun
//   ovr_set      overrun being set this cycle
module ocio_in_port
  import ocio_pkg::*;
#(
  parameter int SYNC_STG = 2,
  parameter int DEB_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OCIO_BYTE_W-1:0] pin,
  input  logic                   stb_pin,
  input  logic [DEB_W-1:0]       deb_len,
  input  logic                   latch_en,
  input  logic                   stb_pol,
  input  logic                   ack,
  input  logic                   err_clr,
  output logic [OCIO_BYTE_W-1:0] data,
  output logic                   pend,
  output logic                   ovr,
  output logic                   ovr_set
);

  logic [SYNC_STG-1:0][OCIO_BYTE_W-1:0] dat_sync;
  logic [SYNC_STG-1:0]                  stb_sync;
  ocio_byte_t                           s_dat;
  ocio_byte_t                           s_dat_p1;
  logic [DEB_W-1:0]                     cnt;
  ocio_byte_t                           deb;
  ocio_byte_t                           lat;
  logic                                 act;
  logic                                 act_p1;
  logic                                 stb_edge;
  logic                                 pend_q;

  assign s_dat    = dat_sync[SYNC_STG-1];
  // Polarity folded in before edge detection so one rising-edge detector
  // serves both strobe senses.
  assign act      = stb_sync[SYNC_STG-1] ^ stb_pol;
  assign stb_edge = act & ~act_p1;
  assign ovr_set  = latch_en & stb_edge & pend_q & ~ack;

  assign data = latch_en ? lat : deb;
  assign pend = pend_q & latch_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_sync <= '0;
      stb_sync <= '0;
      s_dat_p1 <= '0;
      cnt      <= '0;
      deb      <= '0;
      lat      <= '0;
      act_p1   <= 1'b0;
      pend_q   <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      // Synchroniser stage
      dat_sync <= {dat_sync[SYNC_STG-2:0], pin};
      stb_sync <= {stb_sync[SYNC_STG-2:0], stb_pin};

      // Debounce stage: cnt counts consecutive cycles with an unchanged word
      s_dat_p1 <= s_dat;
      if (s_dat != s_dat_p1) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      // A changing word never passes, even if a stale count is high.
      if (deb_len == '0) begin
        deb <= s_dat;
      end else if ((s_dat == s_dat_p1) && (cnt >= deb_len)) begin
        deb <= s_dat;
      end

      // Strobe latch stage: capture beats ack in the same cycle
      act_p1 <= act;
      if (!latch_en) begin
        pend_q <= 1'b0;
      end else if (stb_edge) begin
        lat    <= s_dat;
        pend_q <= 1'b1;
      end else if (ack) begin
        pend_q <= 1'b0;
      end

      // A new overrun beats a simultaneous clear
      if (ovr_set) begin
        ovr <= 1'b1;
      end else if (err_clr) begin
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/frontend_ocio_gen.sv
// OCIO frontend for the SCU DIOB2 plugin slot: N_IN synchronised/debounced
// input ports with optional strobe latching, registered output bytes and
// control lines, delayed output enable, error and interrupt aggregation.
// Optional feature macro: OCIO_IRQ_EN (adds irq_mask input and a registered
// irq; when undefined irq is tied to 0).
// Ports:
//   clk, nReset              clock, asynchronous active-low reset
//   in_pins/strobe_pins      raw input pins and strobes
//   cfg_deb_len/latch/stb_pol input port configuration
//   in_data/in_pend/in_ack   register bank side of input ports
//   out_data/ctrl_data       values to drive; out_pins/ctrl_pins registered
//   oe_req/oe_pin            output-enable request and delayed enable
//   err_clr/overrun/plugin_error  sticky error handling
//   irq_mask/irq             interrupt (irq_mask only with OCIO_IRQ_EN)
module frontend_ocio_gen
  import ocio_pkg::*;
#(
  parameter int N_IN     = 3,
  parameter int N_OUT    = 1,
  parameter int N_CTRL   = 4,
  parameter int SYNC_STG = 2,
  parameter int DEB_W    = 8,
  parameter int OE_DLY   = 16
) (
  input  logic                         clk,
  input  logic                         nReset,
  input  logic [OCIO_BYTE_W*N_IN-1:0]  in_pins,
  input  logic [N_IN-1:0]              strobe_pins,
  input  logic [DEB_W-1:0]             cfg_deb_len,
  input  logic [N_IN-1:0]              cfg_latch,
  input  logic [N_IN-1:0]              cfg_stb_pol,
  output logic [OCIO_BYTE_W*N_IN-1:0]  in_data,
  output logic [N_IN-1:0]              in_pend,
  input  logic [N_IN-1:0]              in_ack,
  input  logic [OCIO_BYTE_W*N_OUT-1:0] out_data,
  input  logic [N_CTRL-1:0]            ctrl_data,
  output logic [OCIO_BYTE_W*N_OUT-1:0] out_pins,
  output logic [N_CTRL-1:0]            ctrl_pins,
  input  logic                         oe_req,
  output logic                         oe_pin,
  input  logic                         err_clr,
  output logic [N_IN-1:0]              overrun,
  output logic                         plugin_error,
`ifdef OCIO_IRQ_EN
  input  logic [N_IN-1:0]              irq_mask,
`endif
  output logic                         irq
);

  localparam int OE_CW = $clog2(OE_DLY + 1);

  logic [N_IN-1:0] ovr_set;
  oe_state_t       oe_state;
  logic [OE_CW-1:0] oe_cnt;

  for (genvar p = 0; p < N_IN; p++) begin : g_in
    ocio_in_port #(
      .SYNC_STG(SYNC_STG),
      .DEB_W   (DEB_W)
    ) u_port (
      .clk     (clk),
      .rst_n   (nReset),
      .pin     (in_pins[OCIO_BYTE_W*p +: OCIO_BYTE_W]),
      .stb_pin (strobe_pins[p]),
      .deb_len (cfg_deb_len),
      .latch_en(cfg_latch[p]),
      .stb_pol (cfg_stb_pol[p]),
      .ack     (in_ack[p]),
      .err_clr (err_clr),
      .data    (in_data[OCIO_BYTE_W*p +: OCIO_BYTE_W]),
      .pend    (in_pend[p]),
      .ovr     (overrun[p]),
      .ovr_set (ovr_set[p])
    );
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      out_pins     <= '0;
      ctrl_pins    <= '0;
      plugin_error <= 1'b0;
    end else begin
      out_pins  <= out_data;
      ctrl_pins <= ctrl_data;
      // Clearing only wins when no port sets an overrun this cycle.
      plugin_error <= err_clr ? |ovr_set : |overrun;
    end
  end

  // OE sequencer: oe_pin rises on the OE_DLY-th edge after oe_req rises.
  // WAIT is entered with cnt=0 and ON is taken as cnt steps to OE_DLY-1.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      oe_state <= OE_OFF;
      oe_cnt   <= '0;
      oe_pin   <= 1'b0;
    end else begin
      case (oe_state)
        OE_OFF: begin
          oe_cnt <= '0;
          if (oe_req) begin
            if (OE_DLY <= 1) begin
              oe_state <= OE_ON;
              oe_pin   <= 1'b1;
            end else begin
              oe_state <= OE_WAIT;
            end
          end
        end
        OE_WAIT: begin
          if (!oe_req) begin
            oe_state <= OE_OFF;
            oe_pin   <= 1'b0;
          end else begin
            oe_cnt <= oe_cnt + 1'b1;
            if (int'(oe_cnt) + 2 >= OE_DLY) begin
              oe_state <= OE_ON;
              oe_pin   <= 1'b1;
            end
          end
        end
        OE_ON: begin
          if (!oe_req) begin
            oe_state <= OE_OFF;
            oe_pin   <= 1'b0;
          end
        end
        default: begin
          oe_state <= OE_OFF;
          oe_pin   <= 1'b0;
        end
      endcase
    end
  end

`ifdef OCIO_IRQ_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      irq <= 1'b0;
    end else begin
      irq <= (|(in_pend & irq_mask)) | plugin_error;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule
